// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache with one-beat line refill.
// Define ICACHE_DUAL_FETCH_EN to also return the following word of the line.
module icache_dm #(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 32,
    parameter int INDEX_W    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         cpu_req_valid,
    output logic                         cpu_req_ready,
    input  logic [ADDR_W-1:0]            cpu_addr,
    output logic                         cpu_resp_valid,
    output logic [WORD_W-1:0]            cpu_rdata,
    output logic [WORD_W-1:0]            cpu_rdata2,
    output logic                         cpu_rdata2_valid,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic                         mem_resp_valid,
    input  logic [WORD_W*LINE_WORDS-1:0] mem_rdata
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = ADDR_W - OFF_W - INDEX_W;
    localparam int SETS  = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT} state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0]                  addr_q;
    logic [SETS-1:0]                    valid;
    logic                               pend_flush;
    logic [TAG_W-1:0]                   tags  [SETS];
    logic [LINE_WORDS-1:0][WORD_W-1:0]  lines [SETS];

    logic [OFF_W-1:0]                   off;
    logic [INDEX_W-1:0]                 idx;
    logic [TAG_W-1:0]                   tag;
    logic                               hit;
    logic                               fill;
    logic                               done;
    logic [LINE_WORDS-1:0][WORD_W-1:0]  src;

    assign off  = addr_q[OFF_W-1:0];
    assign idx  = addr_q[OFF_W+INDEX_W-1:OFF_W];
    assign tag  = addr_q[ADDR_W-1:OFF_W+INDEX_W];
    assign hit  = valid[idx] && (tags[idx] == tag);
    assign fill = (state == MISS_WAIT) && mem_resp_valid;
    assign done = ((state == LOOKUP) && hit) || fill;
    // A refill answers straight from the incoming line, not the array
    assign src  = fill ? mem_rdata : lines[idx];

`ifdef ICACHE_DUAL_FETCH_EN
    logic [OFF_W-1:0] nxt;
    logic             last;

    assign nxt  = off + OFF_W'(1);
    assign last = &off;
`else
    assign cpu_rdata2       = '0;
    assign cpu_rdata2_valid = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (cpu_req_valid && !flush) state_nx = LOOKUP;
            LOOKUP:    state_nx = hit ? IDLE : MISS_REQ;
            MISS_REQ:  if (mem_req_ready) state_nx = MISS_WAIT;
            MISS_WAIT: if (mem_resp_valid) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        cpu_req_ready = (state == IDLE) && !flush;
        mem_req_valid = (state == MISS_REQ);
    end

    // Valid bits, deferred flush, request address and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid          <= '0;
            pend_flush     <= 1'b0;
            addr_q         <= '0;
            mem_addr       <= '0;
            cpu_resp_valid <= 1'b0;
            cpu_rdata      <= '0;
`ifdef ICACHE_DUAL_FETCH_EN
            cpu_rdata2       <= '0;
            cpu_rdata2_valid <= 1'b0;
`endif
        end else begin
            cpu_resp_valid <= done;
            if (state == IDLE) begin
                if (flush) valid <= '0;
                else if (cpu_req_valid) addr_q <= cpu_addr;
                pend_flush <= 1'b0;
            end else if (done) begin
                if (flush || pend_flush) valid <= '0;
                else if (fill) valid[idx] <= 1'b1;
                pend_flush <= 1'b0;
            end else if (flush) begin
                pend_flush <= 1'b1;
            end
            if ((state == LOOKUP) && !hit)
                mem_addr <= {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            if (done) begin
                cpu_rdata <= src[off];
`ifdef ICACHE_DUAL_FETCH_EN
                cpu_rdata2       <= last ? '0 : src[nxt];
                cpu_rdata2_valid <= !last;
`endif
            end
        end
    end

    // Line and tag storage; contents are meaningless until valid is set
    always_ff @(posedge clk) begin
        if (fill) begin
            lines[idx] <= mem_rdata;
            tags[idx]  <= tag;
        end
    end
endmodule
